jet_tag_decision: RTL and testbench

Downstream consumer of the jet-tagging network core. Captures the five class scores (Q6.10 fixed point), which the core presents on independent per-lane valid strobes that cannot be back-pressured. Once all lanes are in, runs a sequential argmax scan and presents winning class, winning score and top-2 margin on a valid/ready output. An optional build feature keeps per-class prediction counters.

---
 rtl/jet_tag_pkg.sv | 22 ++
 rtl/jet_tag_hist.sv | 36 +++
 rtl/jet_tag_decision.sv | 136 +++++++++++++
 tb/tb_jet_tag_decision.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jet_tag_pkg.sv
// Shared types and constants for the jet-tag decision stage.
package jet_tag_pkg;

    localparam int unsigned N_CLASS = 5;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NFRAC   = 10;
    localparam int unsigned IDX_W   = $clog2(N_CLASS);

    typedef logic signed [WIDTH-1:0] score_t;
    typedef logic [IDX_W-1:0]        class_idx_t;
    typedef logic [WIDTH:0]          margin_t;

    typedef enum logic [1:0] {COLLECT, SCAN, OUT} state_t;

    localparam score_t SCORE_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Sign-extend both operands by one bit so the difference cannot overflow.
    function automatic margin_t calc_margin(score_t hi, score_t lo);
        return {hi[WIDTH-1], hi} - {lo[WIDTH-1], lo};
    endfunction

endpackage

// File: rtl/jet_tag_hist.sv
// Per-class saturating prediction counters with synchronous clear and registered read.
module jet_tag_hist
    import jet_tag_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             inc_i,
    input  class_idx_t       inc_sel_i,
    input  logic             clr_i,
    input  class_idx_t       rd_sel_i,
    output logic [CNT_W-1:0] rd_cnt_o
);

    logic [CNT_W-1:0] cnt_q [N_CLASS];
    logic [CNT_W-1:0] rd_cnt_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < N_CLASS; k++) cnt_q[k] <= '0;
            rd_cnt_q <= '0;
        end else begin
            // Clear takes priority over a coincident increment.
            if (clr_i) begin
                for (int k = 0; k < N_CLASS; k++) cnt_q[k] <= '0;
            end else if (inc_i && (32'(inc_sel_i) < N_CLASS)) begin
                if (cnt_q[inc_sel_i] != '1) cnt_q[inc_sel_i] <= cnt_q[inc_sel_i] + 1'b1;
            end
            rd_cnt_q <= (32'(rd_sel_i) < N_CLASS) ? cnt_q[rd_sel_i] : '0;
        end
    end

    assign rd_cnt_o = rd_cnt_q;

endmodule

// File: rtl/jet_tag_decision.sv
// Captures per-lane class scores, runs a sequential argmax/top-2 scan, presents the result.
// Optional build feature JET_TAG_HIST_EN adds per-class prediction counters.
module jet_tag_decision
    import jet_tag_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [N_CLASS*WIDTH-1:0] score_i,
    input  logic [N_CLASS-1:0]       score_vld_i,
    output logic                     in_ready_o,
    output logic                     overrun_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [IDX_W-1:0]         out_class_o,
    output logic [WIDTH-1:0]         out_score_o,
    output logic [WIDTH:0]           out_margin_o,
    input  logic [IDX_W-1:0]         hist_sel_i,
    input  logic                     hist_clr_i,
    output logic [CNT_W-1:0]         hist_cnt_o
);

    localparam class_idx_t LAST_IDX = class_idx_t'(N_CLASS - 1);

    state_t           state_q;
    logic [N_CLASS-1:0] mask_q;
    logic [N_CLASS-1:0] mask_nxt;
    score_t           score_q [N_CLASS];
    class_idx_t       scan_idx_q;
    score_t           max_q, max_d;
    score_t           sec_q, sec_d;
    class_idx_t       cls_q, cls_d;
    score_t           cur;
    logic             overrun_q;
    class_idx_t       out_class_q;
    score_t           out_score_q;
    margin_t          out_margin_q;

    assign mask_nxt = mask_q | score_vld_i;
    assign cur      = score_q[scan_idx_q];

    // One scan step; strict greater-than keeps the lowest index on ties.
    always_comb begin
        max_d = max_q;
        sec_d = sec_q;
        cls_d = cls_q;
        if (scan_idx_q == '0) begin
            max_d = cur;
            sec_d = SCORE_MIN;
            cls_d = '0;
        end else if (cur > max_q) begin
            sec_d = max_q;
            max_d = cur;
            cls_d = scan_idx_q;
        end else if (cur > sec_q) begin
            sec_d = cur;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= COLLECT;
            mask_q       <= '0;
            for (int k = 0; k < N_CLASS; k++) score_q[k] <= '0;
            scan_idx_q   <= '0;
            max_q        <= '0;
            sec_q        <= '0;
            cls_q        <= '0;
            overrun_q    <= 1'b0;
            out_class_q  <= '0;
            out_score_q  <= '0;
            out_margin_q <= '0;
        end else begin
            if ((state_q != COLLECT) && (|score_vld_i)) overrun_q <= 1'b1;
            unique case (state_q)
                COLLECT: begin
                    for (int k = 0; k < N_CLASS; k++) begin
                        if (score_vld_i[k]) score_q[k] <= score_i[k*WIDTH +: WIDTH];
                    end
                    mask_q <= mask_nxt;
                    if (&mask_nxt) begin
                        state_q    <= SCAN;
                        scan_idx_q <= '0;
                    end
                end
                SCAN: begin
                    max_q <= max_d;
                    sec_q <= sec_d;
                    cls_q <= cls_d;
                    if (scan_idx_q == LAST_IDX) begin
                        state_q      <= OUT;
                        out_class_q  <= cls_d;
                        out_score_q  <= max_d;
                        out_margin_q <= calc_margin(max_d, sec_d);
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        mask_q  <= '0;
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign in_ready_o   = (state_q == COLLECT);
    assign out_valid_o  = (state_q == OUT);
    assign overrun_o    = overrun_q;
    assign out_class_o  = out_class_q;
    assign out_score_o  = out_score_q;
    assign out_margin_o = out_margin_q;

`ifdef JET_TAG_HIST_EN
    jet_tag_hist #(
        .CNT_W(CNT_W)
    ) u_hist (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .inc_i    (out_valid_o && out_ready_i),
        .inc_sel_i(out_class_o),
        .clr_i    (hist_clr_i),
        .rd_sel_i (hist_sel_i),
        .rd_cnt_o (hist_cnt_o)
    );
`else
    logic unused_hist;
    assign unused_hist = ^{hist_sel_i, hist_clr_i};
    assign hist_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_jet_tag_decision.sv
// Directed table-driven bench for jet_tag_decision plus multi-cycle corner sequences.
module tb_jet_tag_decision;
    import jet_tag_pkg::*;

    logic                     ap_clk;
    logic                     ap_rst_n;
    logic [N_CLASS*WIDTH-1:0] score_i;
    logic [N_CLASS-1:0]       score_vld_i;
    logic                     in_ready_o;
    logic                     overrun_o;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [IDX_W-1:0]         out_class_o;
    logic [WIDTH-1:0]         out_score_o;
    logic [WIDTH:0]           out_margin_o;
    logic [IDX_W-1:0]         hist_sel_i;
    logic                     hist_clr_i;
    logic [31:0]              hist_cnt_o;

    jet_tag_decision dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .score_i     (score_i),
        .score_vld_i (score_vld_i),
        .in_ready_o  (in_ready_o),
        .overrun_o   (overrun_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_class_o (out_class_o),
        .out_score_o (out_score_o),
        .out_margin_o(out_margin_o),
        .hist_sel_i  (hist_sel_i),
        .hist_clr_i  (hist_clr_i),
        .hist_cnt_o  (hist_cnt_o)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [79:0] sc;
        logic [2:0]  cls;
        logic [15:0] score;
        logic [16:0] margin;
    } vec_t;

    vec_t tbl [8];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [79:0] pk(int a, int b, int c, int d, int e);
        return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic apply_all(input logic [79:0] sc);
        score_i     = sc;
        score_vld_i = '1;
        tick();
        score_vld_i = '0;
    endtask

    // Called in the cycle after the completing strobe; n is the cycle offset from it.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid_o && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, "_class"}, 32'(out_class_o), 32'(v.cls));
        chk({tag, "_score"}, 32'(out_score_o), 32'(v.score));
        chk({tag, "_margin"}, 32'(out_margin_o), 32'(v.margin));
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        out_ready_i = 1'b1;
        apply_all(v.sc);
        wait_valid(n);
        chk("run_latency", 32'(n), 32'd6);
        chk_result("run", v);
        tick();
    endtask

    initial begin
        int   n;
        vec_t v;
        logic ok;

        tbl[0] = '{pk(1024, -512, 2048, 300, 2047), 3'd2, 16'd2048, 17'd1};
        tbl[1] = '{pk(700, 500, 500, 700, -1), 3'd0, 16'd700, 17'd0};
        tbl[2] = '{pk(-32768, -32768, -32768, -32768, 32767), 3'd4, 16'd32767, 17'd65535};
        tbl[3] = '{pk(-5, -5, -5, -5, -5), 3'd0, 16'(-5), 17'd0};
        tbl[4] = '{pk(-100, -200, -50, -300, -400), 3'd2, 16'(-50), 17'd50};
        tbl[5] = '{pk(1000, 10, 20, 30, 1001), 3'd4, 16'd1001, 17'd1};
        tbl[6] = '{pk(-32768, -32768, -32768, -32768, -32768), 3'd0, 16'h8000, 17'd0};
        tbl[7] = '{pk(0, 32767, 32767, 0, 0), 3'd1, 16'd32767, 17'd0};

        ap_rst_n    = 1'b0;
        score_i     = '0;
        score_vld_i = '0;
        out_ready_i = 1'b0;
        hist_sel_i  = '0;
        hist_clr_i  = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();

        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_class", 32'(out_class_o), 32'd0);
        chk("rst_score", 32'(out_score_o), 32'd0);
        chk("rst_margin", 32'(out_margin_o), 32'd0);
        chk("rst_hist", hist_cnt_o, 32'd0);

        // Table: all lanes in one cycle, immediate acceptance.
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply_all(tbl[i].sc);
            chk("tbl_busy", 32'(in_ready_o), 32'd0);
            wait_valid(n);
            chk("tbl_latency", 32'(n), 32'd6);
            chk("tbl_in_ready_out", 32'(in_ready_o), 32'd0);
            chk_result("tbl", tbl[i]);
            tick();
            chk("tbl_accept_ready", 32'(in_ready_o), 32'd1);
            chk("tbl_accept_valid", 32'(out_valid_o), 32'd0);
        end
        chk("tbl_no_overrun", 32'(overrun_o), 32'd0);

        // Staggered lanes with a repeat strobe on lane 1.
        for (int c = 0; c < 10; c++) begin
            score_vld_i = '0;
            score_i     = '0;
            case (c)
                0: score_vld_i[0] = 1'b1;
                2: begin
                    score_vld_i[2:1] = 2'b11;
                    score_i[16 +: 16] = 16'(-7);
                end
                5: score_vld_i[3] = 1'b1;
                7: begin
                    score_vld_i[1] = 1'b1;
                    score_i[16 +: 16] = 16'd4000;
                end
                9: score_vld_i[4] = 1'b1;
                default: ;
            endcase
            if (c == 8) chk("stag_collecting", 32'(in_ready_o), 32'd1);
            tick();
        end
        score_vld_i = '0;
        wait_valid(n);
        chk("stag_latency", 32'(n), 32'd6);
        v = '{80'd0, 3'd1, 16'd4000, 17'd4000};
        chk_result("stag", v);
        tick();

        // Backpressure with an overrun strobe during the hold.
        out_ready_i = 1'b0;
        v = '{pk(10, 20, 30, 40, 50), 3'd4, 16'd50, 17'd10};
        apply_all(v.sc);
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'd6);
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                score_i     = pk(9999, 9999, 9999, 9999, 9999);
                score_vld_i = '1;
            end else begin
                score_vld_i = '0;
            end
            tick();
            if (!out_valid_o || in_ready_o || out_class_o !== v.cls ||
                out_score_o !== v.score || out_margin_o !== v.margin) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'd1);
        chk("bp_overrun", 32'(overrun_o), 32'd1);
        chk_result("bp", v);
        out_ready_i = 1'b1;
        tick();
        chk("bp_release_ready", 32'(in_ready_o), 32'd1);
        chk("bp_release_valid", 32'(out_valid_o), 32'd0);
        chk("bp_overrun_sticky", 32'(overrun_o), 32'd1);

`ifdef JET_TAG_HIST_EN
        hist_clr_i = 1'b1;
        tick();
        hist_clr_i = 1'b0;
        run_vec(tbl[0]);
        run_vec(tbl[0]);
        run_vec(tbl[1]);
        run_vec(tbl[0]);
        hist_sel_i = 3'd2;
        tick();
        chk("hist_cls2", hist_cnt_o, 32'd3);
        hist_sel_i = 3'd0;
        tick();
        chk("hist_cls0", hist_cnt_o, 32'd1);
        hist_sel_i = 3'd4;
        tick();
        chk("hist_cls4", hist_cnt_o, 32'd0);
        // Clear coincident with an acceptance.
        out_ready_i = 1'b0;
        apply_all(tbl[0].sc);
        wait_valid(n);
        out_ready_i = 1'b1;
        hist_clr_i  = 1'b1;
        tick();
        hist_clr_i = 1'b0;
        hist_sel_i = 3'd2;
        tick();
        tick();
        chk("hist_clr_cls2", hist_cnt_o, 32'd0);
        hist_sel_i = 3'd0;
        tick();
        chk("hist_clr_cls0", hist_cnt_o, 32'd0);
`else
        run_vec(tbl[0]);
        hist_sel_i = 3'd2;
        tick();
        tick();
        chk("hist_tied", hist_cnt_o, 32'd0);
`endif

        // Mid-scan reset; outputs currently hold a nonzero result and overrun is set.
        out_ready_i = 1'b1;
        apply_all(tbl[5].sc);
        tick();
        tick();
        chk("ms_in_scan", 32'(in_ready_o), 32'd0);
        ap_rst_n = 1'b0;
        #1;
        chk("ms_in_ready", 32'(in_ready_o), 32'd1);
        chk("ms_overrun", 32'(overrun_o), 32'd0);
        chk("ms_valid", 32'(out_valid_o), 32'd0);
        chk("ms_class", 32'(out_class_o), 32'd0);
        chk("ms_score", 32'(out_score_o), 32'd0);
        chk("ms_margin", 32'(out_margin_o), 32'd0);
        chk("ms_hist", hist_cnt_o, 32'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        v = '{pk(5, 4, 3, 2, 1), 3'd0, 16'd5, 17'd1};
        run_vec(v);
        chk("ms_after_ready", 32'(in_ready_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
